// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package riscv_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    D_BUS   = 2'd1,
    I_BUS   = 2'd2,
    D_LOCAL = 2'd3
  } arb_state_e;

  localparam int unsigned TAG_W     = 11;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Core-side fetch/data ports plus the single memory-controller bus, seen from both ends.
interface riscv_mem_arbiter_if;
  import riscv_mem_arbiter_pkg::*;

  logic             mem_i_rd;
  logic [31:0]      mem_i_pc;
  logic             mem_i_accept;
  logic             mem_i_valid;
  logic             mem_i_error;
  logic [31:0]      mem_i_inst;

  logic [31:0]      mem_d_addr;
  logic [31:0]      mem_d_data_wr;
  logic             mem_d_rd;
  logic [3:0]       mem_d_wr;
  logic [TAG_W-1:0] mem_d_req_tag;
  logic             mem_d_flush;
  logic             mem_d_invalidate;
  logic             mem_d_writeback;
  logic             mem_d_accept;
  logic             mem_d_ack;
  logic             mem_d_error;
  logic [31:0]      mem_d_data_rd;
  logic [TAG_W-1:0] mem_d_resp_tag;

  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wstrb;
  logic             mem_we;
  logic             mem_re;
  logic [31:0]      mem_rdata;
  logic             mem_ready;

  // slave: the arbiter; master: the core and memory controller around it.
  modport slave (
    input  mem_i_rd, mem_i_pc,
    output mem_i_accept, mem_i_valid, mem_i_error, mem_i_inst,
    input  mem_d_addr, mem_d_data_wr, mem_d_rd, mem_d_wr, mem_d_req_tag,
    input  mem_d_flush, mem_d_invalidate, mem_d_writeback,
    output mem_d_accept, mem_d_ack, mem_d_error, mem_d_data_rd, mem_d_resp_tag,
    output mem_addr, mem_wdata, mem_wstrb, mem_we, mem_re,
    input  mem_rdata, mem_ready
  );

  modport master (
    output mem_i_rd, mem_i_pc,
    input  mem_i_accept, mem_i_valid, mem_i_error, mem_i_inst,
    output mem_d_addr, mem_d_data_wr, mem_d_rd, mem_d_wr, mem_d_req_tag,
    output mem_d_flush, mem_d_invalidate, mem_d_writeback,
    input  mem_d_accept, mem_d_ack, mem_d_error, mem_d_data_rd, mem_d_resp_tag,
    input  mem_addr, mem_wdata, mem_wstrb, mem_we, mem_re,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/riscv_mem_arbiter_timer.sv
// Bus-access watchdog: counts not-ready cycles and flags the last permitted one.
module riscv_mem_arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, avoiding races.
    if (rst || clear) count <= 8'd0;
    else if (en)      count <= count + 8'd1;
  end

  // High during the waiting cycle whose increment would reach TIMEOUT_CYCLES.
  assign expired = en && (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Serializes core fetch and data requests onto one memory bus, round-robin, with timeout.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  riscv_mem_arbiter_if.slave  bus
);

  arb_state_e       state;
  logic             last_was_d;
  logic             is_write_q;
  logic [TAG_W-1:0] tag_q;

  logic d_maint, d_pend, i_pend, d_local;
  logic grant_d, grant_i, in_bus, expired;

  assign d_maint = bus.mem_d_flush | bus.mem_d_invalidate | bus.mem_d_writeback;
  assign d_pend  = bus.mem_d_rd | (|bus.mem_d_wr) | d_maint;
  assign i_pend  = bus.mem_i_rd;
  assign d_local = !bus.mem_d_rd && (bus.mem_d_wr == 4'd0);

  // NOTE: accepts are full continuous expressions, so no latch can be inferred.
  assign grant_d = (state == IDLE) && !rst && d_pend && (!i_pend || !last_was_d);
  assign grant_i = (state == IDLE) && !rst && i_pend && (!d_pend ||  last_was_d);

  assign bus.mem_d_accept = grant_d;
  assign bus.mem_i_accept = grant_i;

  assign in_bus = (state == D_BUS) || (state == I_BUS);

  riscv_mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_d | grant_i),
    .en      (in_bus && !bus.mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      last_was_d         <= 1'b0;
      is_write_q         <= 1'b0;
      tag_q              <= '0;
      bus.mem_addr       <= '0;
      bus.mem_wdata      <= '0;
      bus.mem_wstrb      <= '0;
      bus.mem_we         <= 1'b0;
      bus.mem_re         <= 1'b0;
      bus.mem_i_valid    <= 1'b0;
      bus.mem_i_error    <= 1'b0;
      bus.mem_i_inst     <= '0;
      bus.mem_d_ack      <= 1'b0;
      bus.mem_d_error    <= 1'b0;
      bus.mem_d_data_rd  <= '0;
      bus.mem_d_resp_tag <= '0;
    end else begin
      bus.mem_i_valid <= 1'b0;
      bus.mem_d_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            last_was_d <= 1'b1;
            tag_q      <= bus.mem_d_req_tag;
            if (d_local) begin
              state              <= D_LOCAL;
              bus.mem_d_ack      <= 1'b1;
              bus.mem_d_error    <= 1'b0;
              bus.mem_d_data_rd  <= '0;
              bus.mem_d_resp_tag <= bus.mem_d_req_tag;
            end else begin
              state         <= D_BUS;
              bus.mem_addr  <= word_align(bus.mem_d_addr);
              bus.mem_wdata <= bus.mem_d_data_wr;
              // A request with both rd and wr set is a store.
              is_write_q    <= |bus.mem_d_wr;
              bus.mem_wstrb <= bus.mem_d_wr;
              bus.mem_we    <= |bus.mem_d_wr;
              bus.mem_re    <= ~(|bus.mem_d_wr);
            end
          end else if (grant_i) begin
            last_was_d <= 1'b0;
            if (bus.mem_i_pc[1:0] != 2'b00) begin
              state           <= D_LOCAL;
              bus.mem_i_valid <= 1'b1;
              bus.mem_i_error <= 1'b1;
              bus.mem_i_inst  <= '0;
            end else begin
              state         <= I_BUS;
              bus.mem_addr  <= bus.mem_i_pc;
              bus.mem_wstrb <= 4'd0;
              bus.mem_re    <= 1'b1;
            end
          end
        end
        D_BUS: begin
          if (bus.mem_ready || expired) begin
            state              <= IDLE;
            bus.mem_we         <= 1'b0;
            bus.mem_re         <= 1'b0;
            bus.mem_d_ack      <= 1'b1;
            bus.mem_d_error    <= !bus.mem_ready;
            bus.mem_d_data_rd  <= (bus.mem_ready && !is_write_q) ? bus.mem_rdata : 32'd0;
            bus.mem_d_resp_tag <= tag_q;
          end
        end
        I_BUS: begin
          if (bus.mem_ready || expired) begin
            state           <= IDLE;
            bus.mem_re      <= 1'b0;
            bus.mem_i_valid <= 1'b1;
            bus.mem_i_error <= !bus.mem_ready;
            bus.mem_i_inst  <= bus.mem_ready ? bus.mem_rdata : 32'd0;
          end
        end
        D_LOCAL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Two-port to one-port memory arbiter between `riscv_core` and `memory_controller`. It accepts the core's instruction-fetch and data-access request ports and serializes them onto the single CPU-side bus of `memory_controller` (addr/wdata/wstrb/we/re/rdata/ready). The block issues one transaction at a time, arbitrates round-robin on conflict, answers cache-maintenance requests locally, and bounds every access with a timeout that returns an error response.

## Interface
- `TIMEOUT_CYCLES`, 16: max cycles a bus access waits for `mem_ready_i` before aborting with error; legal range 1..255.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset. **One clock; reset is synchronous and active-high.**
- `mem_i_rd_i`  in  1  fetch request, held until accepted.
- `mem_i_pc_i`  in  32  fetch address.
- `mem_i_accept_o`  out  1  fetch request taken this cycle.
- `mem_i_valid_o`  out  1  one-cycle fetch response.
- `mem_i_error_o`  out  1  fetch response is an error; qualified by `mem_i_valid_o`.
- `mem_i_inst_o`  out  32  fetched word.
- `mem_d_addr_i`  in  32  data address.
- `mem_d_data_wr_i`  in  32  store data.
- `mem_d_rd_i`  in  1  load request.
- `mem_d_wr_i`  in  4  store byte strobes; nonzero means store.
- `mem_d_req_tag_i`  in  11  request tag.
- `mem_d_flush_i`, `mem_d_invalidate_i`, `mem_d_writeback_i`  in  1 each  cache-maintenance requests.
- `mem_d_accept_o`  out  1  data request taken this cycle.
- `mem_d_ack_o`  out  1  one-cycle data response.
- `mem_d_error_o`  out  1  data response is an error.
- `mem_d_data_rd_o`  out  32  load data.
- `mem_d_resp_tag_o`  out  11  echo of the accepted tag.
- `mem_addr_o`  out  32  bus address, word-aligned (`[1:0]` = 0).
- `mem_wdata_o`  out  32  bus write data.
- `mem_wstrb_o`  out  4  bus byte strobes.
- `mem_we_o`, `mem_re_o`  out  1 each  bus write/read strobes, held until ready.
- `mem_rdata_i`  in  32  bus read data, valid when `mem_ready_i`=1.
- `mem_ready_i`  in  1  bus completion.

## Operation
- FSM states: IDLE, D_BUS, I_BUS, D_LOCAL.
- A data request is any of the following: `mem_d_rd_i`, `|mem_d_wr_i`, or a maintenance request.
- **IDLE:** accept decisions are combinational.
  - Only D pending: `mem_d_accept_o`=1.
  - Only I pending: `mem_i_accept_o`=1.
  - Both pending: grant the port not served last (the `last_was_d` flag; reset value 0, so D wins first).
  - Accepting registers addr, wdata, strobes and tag.
- **State after a D accept:**
  - Maintenance-only request goes to D_LOCAL.
  - Load or store goes to D_BUS. If `wr` and `rd` are both set, the access is a write.
- **State after an I accept:**
  - `pc[1:0]`≠0: go to D_LOCAL-equivalent error path. Respond with `mem_i_valid_o`=1 and `mem_i_error_o`=1 next cycle, with no bus access.
  - Otherwise go to I_BUS.
- **D_BUS / I_BUS:**
  - Drive `mem_re_o` or `mem_we_o` continuously, with stable addr, wdata and wstrb.
  - Instruction reads use `mem_wstrb_o`=0.
  - On `mem_ready_i`=1: register rdata, drop strobes, go to IDLE, and pulse the response next cycle.
- **D_LOCAL:** pulse `mem_d_ack_o` with tag and error=0, then return to IDLE.
- **Timeout:**
  - The counter clears on entry to a BUS state and increments each cycle `mem_ready_i`=0.
  - When count reaches `TIMEOUT_CYCLES` without ready: drop strobes, respond with error=1 and data 0, go to IDLE.
- Stores return `mem_d_data_rd_o`=0.
- The response tag always equals the accepted tag.
- No request is accepted while a transaction is in flight; both accepts are 0 outside IDLE.
- Response outputs are registered one-cycle pulses; data, tag and error hold their value until the next response.

## Timing
- All outputs reset to 0.
  - The FSM resets to IDLE.
  - `last_was_d` resets to 0.
  - The counter resets to 0.
- **Bus access latency:** accept at cycle 0, strobe from cycle 1, ready at cycle N≥1, response pulse at N+1.
  - With a zero-wait bus (ready in cycle 1), the response arrives at cycle 2, and the next accept is possible at cycle 2.
- **Local and misaligned-fetch response:** accept at cycle 0, response at cycle 1.
- **Timeout response:** the strobe is high exactly `TIMEOUT_CYCLES` cycles, and the error pulse comes the following cycle.
- **Reset mid-transaction:** takes effect at the next edge. Strobes drop, no response is generated, and the captured request is discarded.
- **Ready outside a BUS state:** ignored.
- **Ready on the same cycle the timeout is reached:** counts as success.

## Structure
- The following go in `riscv_defs.v` as defines:
  - FSM state encodings (2 bits).
  - Tag width (11).
  - Word-alignment mask.
- One sub-module, `riscv_mem_arb_timer`: an 8-bit counter with clear/enable/expired (`TIMEOUT_CYCLES` parameter).
- The rest (FSM, request capture, response registers) stays in the top module.

## Test plan
- **Zero-wait load:** D load at addr 0x104 with tag 0x2A; bus ready in cycle 1 with rdata 0xDEADBEEF. Expect `mem_d_ack_o` at cycle 2 with data 0xDEADBEEF, tag 0x2A, error 0.
- **Simultaneous I and D requests from reset:** D is accepted first, I next. Back-to-back collisions alternate I/D/I/D. Store `wr`=4'b0011 to 0x203 appears as addr 0x200, wstrb 0011.
- **Wait states:** ready after 3 wait cycles. `mem_re_o` is held for 4 cycles with stable address, and the response follows one cycle after ready.
- **Timeout at `TIMEOUT_CYCLES`=4 with ready never asserted:** strobe high 4 cycles, then `mem_i_valid_o`=1 with error=1 and inst 0. The next request proceeds normally.
- **Local and misaligned requests:**
  - `mem_d_flush_i` gets an ack the next cycle with no bus strobe.
  - Fetch at pc 0x102 gets `mem_i_valid_o`+`mem_i_error_o` the next cycle with no bus strobe.
- **`rst_i` during wait state:** strobes drop at the next edge, no response pulse, all outputs 0. D wins the first post-reset collision.
